// File: rtl/npu_host_seq.sv
// npu_host_seq: bus initiator that loads an inference job from a word source
// into the NPU slave port, streams fc1 groups, polls and returns the logit.
// Ports: clk, rst (async, active-high), start, busy, done, err, result,
//   src_re/src_addr/src_rdata (1-cycle read latency source),
//   npu_ena/npu_wea/npu_addra/npu_dina/npu_douta (slave port, comb read).
// Optional: NPU_HOST_TIMEOUT_EN bounds every poll wait to POLL_MAX reads.
module npu_host_seq #(
  parameter int IMG_WORDS        = 60,
  parameter int WC_WORDS         = 23,
  parameter int FC2_WORDS        = 3,
  parameter int FC1_WORDS        = 330,
  parameter int CONV_WAIT_CYCLES = 2048,
  parameter int POLL_MAX         = 4096,
  parameter int SRC_AW           = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       result,
  output logic              src_re,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic              npu_ena,
  output logic              npu_wea,
  output logic [15:0]       npu_addra,
  output logic [31:0]       npu_dina,
  input  logic [31:0]       npu_douta
);

`ifdef NPU_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int WW = $clog2(FC1_WORDS + 1);
  localparam logic [WW-1:0] FC1_LAST  = WW'(FC1_WORDS - 1);
  localparam logic [15:0]   CONV_LAST = 16'(CONV_WAIT_CYCLES - 1);
  localparam logic [15:0]   POLL_LAST = 16'(POLL_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_FETCH, S_LD_WR, S_GAP, S_TRIG, S_CONV_WAIT,
    S_FC1_FETCH, S_FC1_WR, S_FC1_LATCH, S_FC1_NEXT, S_FC1_POLL,
    S_DONE_POLL, S_RES_RD, S_FINISH
  } state_t;

  state_t            state, state_nx;
  state_t            ret, ret_nx;
  logic [SRC_AW-1:0] saddr;
  logic [WW-1:0]     wcnt;
  logic [1:0]        seg;
  logic [15:0]       cnt;
  logic              err_q;
  logic [31:0]       res_q;
  logic [2:0]        seg_sel;
  logic [WW-1:0]     seg_last;
  logic              seg_end;
  logic              poll_to;

  always_comb begin
    seg_sel  = 3'b110;
    seg_last = WW'(IMG_WORDS - 1);
    unique case (seg)
      2'd0: begin seg_sel = 3'b110; seg_last = WW'(IMG_WORDS - 1); end
      2'd1: begin seg_sel = 3'b001; seg_last = WW'(WC_WORDS - 1);  end
      2'd2: begin seg_sel = 3'b010; seg_last = WW'(WC_WORDS - 1);  end
      2'd3: begin seg_sel = 3'b100; seg_last = WW'(FC2_WORDS - 1); end
    endcase
  end

  assign seg_end = (wcnt == seg_last);
  assign poll_to = TO_EN && (cnt == POLL_LAST);

  // Every bus op goes through S_GAP (ret holds where to resume) so the
  // slave sees at most one enabled cycle in a row.
  always_comb begin
    state_nx  = state;
    ret_nx    = ret;
    src_re    = 1'b0;
    src_addr  = '0;
    npu_ena   = 1'b0;
    npu_wea   = 1'b0;
    npu_addra = '0;
    npu_dina  = '0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LD_FETCH;
      S_LD_FETCH: begin
        src_re   = 1'b1;
        src_addr = saddr;
        state_nx = S_LD_WR;
      end
      S_LD_WR: begin
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = {1'b0, seg_sel, 12'(wcnt)};
        npu_dina  = src_rdata;
        state_nx  = S_GAP;
        ret_nx    = (seg_end && seg == 2'd3) ? S_TRIG : S_LD_FETCH;
      end
      S_GAP: state_nx = ret;
      S_TRIG: begin
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = {1'b0, 3'b101, 12'd1};
        npu_dina  = 32'd1;
        state_nx  = S_GAP;
        ret_nx    = S_CONV_WAIT;
      end
      S_CONV_WAIT: if (cnt == CONV_LAST) state_nx = S_FC1_FETCH;
      S_FC1_FETCH: begin
        src_re   = 1'b1;
        src_addr = saddr;
        state_nx = S_FC1_WR;
      end
      S_FC1_WR: begin
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = {1'b0, 3'b011, 12'd0};
        npu_dina  = src_rdata;
        state_nx  = S_GAP;
        ret_nx    = S_FC1_LATCH;
      end
      S_FC1_LATCH: begin
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = {1'b0, 3'b101, 12'd2};
        npu_dina  = 32'd1;
        state_nx  = S_GAP;
        ret_nx    = S_FC1_NEXT;
      end
      S_FC1_NEXT: begin
        npu_ena   = 1'b1;
        npu_wea   = 1'b1;
        npu_addra = {1'b0, 3'b101, 12'd3};
        npu_dina  = 32'd1;
        state_nx  = S_GAP;
        ret_nx    = S_FC1_POLL;
      end
      S_FC1_POLL: begin
        npu_ena   = 1'b1;
        npu_addra = {1'b0, 3'b111, 12'd8};
        state_nx  = S_GAP;
        if (npu_douta[0])
          ret_nx = (wcnt == FC1_LAST) ? S_DONE_POLL : S_FC1_FETCH;
        else if (poll_to)
          state_nx = S_FINISH;
        else
          ret_nx = S_FC1_POLL;
      end
      S_DONE_POLL: begin
        npu_ena   = 1'b1;
        npu_addra = {1'b0, 3'b111, 12'd0};
        state_nx  = S_GAP;
        if (npu_douta[0])
          ret_nx = S_RES_RD;
        else if (poll_to)
          state_nx = S_FINISH;
        else
          ret_nx = S_DONE_POLL;
      end
      S_RES_RD: begin
        npu_ena   = 1'b1;
        npu_addra = {1'b0, 3'b111, 12'd4};
        state_nx  = S_GAP;
        ret_nx    = S_FINISH;
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ret   <= S_IDLE;
      saddr <= '0;
      wcnt  <= '0;
      seg   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      unique case (state)
        S_IDLE: if (start) begin
          saddr <= '0;
          wcnt  <= '0;
          seg   <= '0;
          cnt   <= '0;
          err_q <= 1'b0;
          res_q <= '0;
        end
        S_LD_FETCH, S_FC1_FETCH: saddr <= saddr + 1'b1;
        S_LD_WR: begin
          if (seg_end) begin
            wcnt <= '0;
            seg  <= seg + 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_TRIG, S_FC1_NEXT: cnt <= '0;
        S_CONV_WAIT: cnt <= cnt + 1'b1;
        S_FC1_POLL, S_DONE_POLL: begin
          if (npu_douta[0]) begin
            cnt <= '0;
            if (state == S_FC1_POLL) wcnt <= wcnt + 1'b1;
          end else if (poll_to) begin
            err_q <= 1'b1;
            res_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RES_RD: res_q <= npu_douta;
        default: ;
      endcase
    end
  end

  assign busy   = (state != S_IDLE) && (state != S_FINISH);
  assign done   = (state == S_FINISH);
  assign err    = TO_EN ? err_q : 1'b0;
  assign result = res_q;

endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: directed bench for npu_host_seq with an NPU slave model
// and a scoreboard of expected write ops checked as the DUT issues them.
module tb_npu_host_seq;

  localparam int N_SRC = 439;
  localparam int FC1_N = 330;
`ifdef NPU_HOST_TIMEOUT_EN
  localparam int DELAY = 10;
`else
  localparam int DELAY = 50;
`endif
  localparam logic [15:0] A_ST0 = {1'b0, 3'b111, 12'd0};
  localparam logic [15:0] A_ST4 = {1'b0, 3'b111, 12'd4};
  localparam logic [15:0] A_ST8 = {1'b0, 3'b111, 12'd8};
  localparam logic [15:0] A_C1  = {1'b0, 3'b101, 12'd1};
  localparam logic [15:0] A_C2  = {1'b0, 3'b101, 12'd2};
  localparam logic [15:0] A_C3  = {1'b0, 3'b101, 12'd3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [31:0] result;
  logic        src_re;
  logic [9:0]  src_addr;
  logic [31:0] src_rdata = '0;
  logic        npu_ena, npu_wea;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina;
  logic [31:0] npu_douta;

  always #5 clk = ~clk;

  npu_host_seq #(.POLL_MAX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err(err), .result(result), .src_re(src_re), .src_addr(src_addr),
    .src_rdata(src_rdata), .npu_ena(npu_ena), .npu_wea(npu_wea),
    .npu_addra(npu_addra), .npu_dina(npu_dina), .npu_douta(npu_douta)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem [0:N_SRC-1];

  always @(posedge clk)
    if (src_re && src_addr < 10'(N_SRC)) src_rdata <= mem[src_addr];

  int fc1_cnt, rd8, gcyc;
  bit armed, gv, no_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fc1_cnt <= 0;
      rd8     <= 0;
      gcyc    <= 0;
      armed   <= 1'b0;
    end else begin
      if (npu_ena && npu_wea && npu_addra == A_C3) begin
        armed <= 1'b1;
        gcyc  <= 0;
        rd8   <= 0;
      end else if (armed) begin
        gcyc <= gcyc + 1;
      end
      if (npu_ena && npu_wea && npu_addra[14:12] == 3'b011) begin
        fc1_cnt <= fc1_cnt + 1;
        armed   <= 1'b0;
      end
      if (npu_ena && !npu_wea && npu_addra == A_ST8 && !gv)
        rd8 <= rd8 + 1;
    end
  end

  // group-valid shows up two cycles after the idx3 write; word 7 is held
  // off for DELAY extra failing reads
  assign gv = armed && gcyc >= 1 && (fc1_cnt != 8 || rd8 >= DELAY);

  always_comb begin
    npu_douta = 32'h0;
    if (npu_addra == A_ST8)
      npu_douta = {31'b0, gv};
    else if (npu_addra == A_ST0)
      npu_douta = {31'b0, (fc1_cnt == FC1_N) && !no_done};
    else if (npu_addra == A_ST4)
      npu_douta = 32'hFFFFFF85;
  end

  logic [47:0] exp_q [$];
  logic [47:0] e;
  int  n_rd8, n_rd0, n_done, mon_fc1, cyc, trig_cyc;
  bit  prev_ena, gv_ok;

  always @(negedge clk) begin
    cyc++;
    if (npu_ena) begin
      chk("gap", 48'(prev_ena), 48'(0));
      if (npu_wea) begin
        if (exp_q.size() == 0) begin
          chk("extra_wr", 48'(exp_q.size()), 48'(1));
        end else begin
          e = exp_q.pop_front();
          chk("wr", {npu_addra, npu_dina}, e);
        end
        if (npu_addra == A_C1) trig_cyc = cyc;
        if (npu_addra[14:12] == 3'b011) begin
          if (mon_fc1 > 0)
            chk("gv_before_wr", 48'(gv_ok), 48'(1));
          else
            chk("conv_wait", 48'(cyc - trig_cyc >= 2048), 48'(1));
          gv_ok = 1'b0;
          mon_fc1++;
        end
      end else begin
        chk("rd_dina", 48'(npu_dina), 48'(0));
        if (npu_addra == A_ST8) begin
          n_rd8++;
          if (npu_douta[0]) gv_ok = 1'b1;
        end
        if (npu_addra == A_ST0) n_rd0++;
      end
    end
    if (done) n_done++;
    prev_ena = npu_ena;
  end

  task automatic reset_mon();
    exp_q.delete();
    n_rd8 = 0; n_rd0 = 0; n_done = 0; mon_fc1 = 0; gv_ok = 1'b0;
  endtask

  task automatic push_seg(input logic [2:0] sel, input int len, inout int n);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b0, sel, 12'(i), mem[n]});
      n++;
    end
  endtask

  task automatic build_q();
    int n = 0;
    push_seg(3'b110, 60, n);
    push_seg(3'b001, 23, n);
    push_seg(3'b010, 23, n);
    push_seg(3'b100, 3, n);
    exp_q.push_back({A_C1, 32'd1});
    for (int w = 0; w < FC1_N; w++) begin
      exp_q.push_back({1'b0, 3'b011, 12'd0, mem[n]});
      exp_q.push_back({A_C2, 32'd1});
      exp_q.push_back({A_C3, 32'd1});
      n++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_start", 48'(busy), 48'(1));
  endtask

  task automatic run_job(input bit poke);
    int c = 0;
    bit poked = 1'b0;
    pulse_start();
    while (!done && c < 40000) begin
      @(negedge clk);
      c++;
      if (start) start = 1'b0;
      if (poke && !poked && mon_fc1 == 100) begin
        start = 1'b1;
        poked = 1'b1;
        chk("busy_at_poke", 48'(busy), 48'(1));
      end
    end
    chk("done_seen", 48'(done), 48'(1));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk(tag, {busy, done, err, src_re, npu_ena, npu_wea, src_addr, npu_addra},
        48'(0));
    chk({tag, "_res"}, 48'(result), 48'(0));
    chk({tag, "_dina"}, 48'(npu_dina), 48'(0));
  endtask

  initial begin
    int c;
    for (int i = 0; i < N_SRC; i++) mem[i] = $urandom;
    no_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b0;

    reset_mon();
    build_q();
    run_job(1'b1);
    chk("err", 48'(err), 48'(0));
    chk("result", 48'(result), 48'hFFFFFF85);
    chk("q_left", 48'(exp_q.size()), 48'(0));
    chk("rd8", 48'(n_rd8), 48'(FC1_N + DELAY));
    chk("rd0", 48'(n_rd0), 48'(1));
    @(negedge clk);
    chk("busy_after", 48'(busy), 48'(0));
    repeat (4) @(negedge clk);
    chk("done_pulses", 48'(n_done), 48'(1));
    chk("result_held", 48'(result), 48'hFFFFFF85);

    reset_mon();
    build_q();
    pulse_start();
    c = 0;
    while (!(npu_ena && npu_addra == A_ST8) && c < 40000) begin
      @(negedge clk);
      c++;
    end
    chk("poll_seen", 48'(npu_ena && npu_addra == A_ST8), 48'(1));
    rst = 1'b1;
    #1;
    chk_zero_outs("mid_rst");
    repeat (2) @(negedge clk);
    chk("rst_quiet", 48'(npu_ena), 48'(0));
    rst = 1'b0;
    reset_mon();
    build_q();
    run_job(1'b0);
    chk("rerun_result", 48'(result), 48'hFFFFFF85);
    chk("rerun_q_left", 48'(exp_q.size()), 48'(0));
    chk("rerun_err", 48'(err), 48'(0));
    @(negedge clk);

`ifdef NPU_HOST_TIMEOUT_EN
    reset_mon();
    build_q();
    no_done = 1'b1;
    run_job(1'b0);
    chk("to_err", 48'(err), 48'(1));
    chk("to_result", 48'(result), 48'(0));
    chk("to_rd0", 48'(n_rd0), 48'(16));
    chk("to_q_left", 48'(exp_q.size()), 48'(0));
    @(negedge clk);
    chk("to_busy", 48'(busy), 48'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_host_seq.md
Name: npu_host_seq

Overview:
- Bus initiator for the NPU memory-mapped slave port. Fetches a complete inference job from a synchronous word source memory and loads the image, conv1/conv2 weights and fc2 weights.
- Then triggers the NPU, streams fc1 weight words with a per-group handshake, polls for completion and returns the signed logit.
- Replaces firmware-driven loading in the SoC and test harness.

Parameters:
- IMG_WORDS, 60, image words (240 bytes, 4 bytes/word).
- WC_WORDS, 23, words per conv weight set (90 bytes; upper 2 bytes of last word don't-care).
- FC2_WORDS, 3, fc2 weight words (10 bytes).
- FC1_WORDS, 330, fc1 stream words (4 PE weights each).
- CONV_WAIT_CYCLES, 2048, fixed cycles between trigger write and first fc1 word.
- POLL_MAX, 4096, max polls per wait (timeout feature only).
- SRC_AW, 10, source address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse; ignored while busy
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  timeout flag, valid with done, held until next start
- result  out  32  signed logit as read, held until next start
- src_re  out  1  source read enable
- src_addr  out  SRC_AW  source word address
- src_rdata  in  32  source data, valid cycle after src_re
- npu_ena  out  1  NPU port enable
- npu_wea  out  1  NPU write enable
- npu_addra  out  16  {1'b0, sel[2:0], idx[11:0]}
- npu_dina  out  32  write data, byte0 = [7:0]
- npu_douta  in  32  read data, combinational, same cycle as read

Behaviour:
- Reset: busy=0, done=0, err=0, result=0, src_re=0, src_addr=0, npu_ena=0, npu_wea=0, npu_addra=0, npu_dina=0. State IDLE. Reset mid-job aborts immediately; no further bus cycles.
- Source layout, contiguous from 0: image, conv1, conv2, fc2, fc1. Totals: 60 + 23 + 23 + 3 + 330 = 439 words.
- Sel codes: 110 image, 001 conv1, 010 conv2, 100 fc2, 011 fc1 word, 101 control, 111 status.
- Control writes use data 1 and idx: 1 trigger, 2 latch fc1 word, 3 fc1 next.
- Status reads use idx: 0 done[0], 4 result, 8 group-valid[0].
- Bus op timing: exactly one cycle with npu_ena=1. Every op is followed by one idle cycle (npu_ena=0), because the slave registers writes.
- Load word: FETCH cycle (src_re=1, src_addr=n), then WRITE cycle (npu_dina=src_rdata, idx=word index within segment), then gap. 3 cycles per word.
- States:
  - IDLE: start goes to LOAD; busy=1, err=0, result=0.
  - LOAD: segments image, conv1, conv2, fc2 in that order; idx restarts at 0 per segment; then TRIG.
  - TRIG: write ctrl idx1, then CONV_WAIT.
  - CONV_WAIT: count CONV_WAIT_CYCLES, then FC1_FETCH.
  - FC1_FETCH: src read.
  - FC1_WR: write sel 011, idx 0.
  - FC1_LATCH: write ctrl idx2.
  - FC1_NEXT: write ctrl idx3.
  - FC1_POLL: read status idx8 every other cycle until bit0=1. Then advance the word counter; go to FC1_FETCH, or DONE_POLL after word FC1_WORDS-1.
  - DONE_POLL: read status idx0 until bit0=1, then RES_RD.
  - RES_RD: read idx4; result=npu_douta (already sign-extended by the NPU), then FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- npu_douta is sampled only in the cycle the read is driven.
- npu_dina=0 on control and read cycles.
- start asserted in the same cycle as FINISH is ignored.
- Counters saturate-free: the word counter is wide enough for 330.

Optional Feature:
- Macro NPU_HOST_TIMEOUT_EN.
- When defined: each FC1_POLL and DONE_POLL wait counts reads. On reaching POLL_MAX without success, go to FINISH with err=1 and result=0. No further bus ops.
- When undefined: polls are unbounded; err is tied to 0.

Test Plan:
- Reset then start with a slave model that sets group-valid 2 cycles after each idx3 and reports done/result after word 329 → exactly 60+23+23+3 load writes with correct sel/idx/data, one trigger, 330×(wr, idx2, idx3) groups in order; single done pulse; busy low afterwards.
- Slave result 24'hFFFF85 read as 32'hFFFFFF85 → result=32'hFFFFFF85, err=0.
- Slave delays group-valid by 50 reads on word 7 → 50 extra idx8 reads; no fc1 write for word 8 before valid seen.
- start pulsed while busy at word 100 → ignored; no restart; job completes normally.
- rst asserted during FC1_POLL → all outputs 0 within the same cycle; a new start reruns from image word 0.
- With NPU_HOST_TIMEOUT_EN, POLL_MAX=16, slave never sets done → exactly 16 idx0 reads, done pulse with err=1, result=0.
